// File: rtl/topworld_pkg.sv
// Shared constants for the switch/display adder: active-low seven-segment
// patterns for hex digits 0-F and the blank pattern.
package topworld_pkg;

  localparam int NUM_SW   = 7;
  localparam int NUM_SEGS = 7;

  localparam logic [NUM_SEGS-1:0] SEG_BLANK = 7'b1111111;

  // Bit order is {a,b,c,d,e,f,g}; 0 lights the segment.
  localparam logic [NUM_SEGS-1:0] SEG_HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder used as one stage of the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to active-low seven-segment pattern lookup.
module hex_to_7seg
  import topworld_pkg::*;
(
  input  logic [3:0]          hex,
  output logic [NUM_SEGS-1:0] seg
);

  assign seg = SEG_HEX[hex];

endmodule

// File: rtl/topworld.sv
// Synchronized 3-bit + carry-in adder driving one registered hex digit on a
// seven-segment display; no combinational path from switches to cathodes.
module topworld
  import topworld_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic Cin,
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  output logic CA,
  output logic CB,
  output logic CC,
  output logic CD,
  output logic CE,
  output logic CF,
  output logic CG
);

  // Switch bit layout: [2:0] = A, [5:3] = B, [6] = carry-in.
  logic [NUM_SW-1:0]   sw;
  logic [NUM_SW-1:0]   sw_sync;
  logic [3:0]          carry;
  logic [3:0]          sum;
  logic [NUM_SEGS-1:0] seg_next;
  logic [NUM_SEGS-1:0] seg_reg;

  assign sw = {Cin, b2, b1, b0, a2, a1, a0};

  generate
    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          chain_reg <= '0;
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], sw[gi]};
        end
      end

      assign sw_sync[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  assign carry[0] = sw_sync[6];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_adder
      full_adder u_fa (
        .a    (sw_sync[gi]),
        .b    (sw_sync[gi+3]),
        .cin  (carry[gi]),
        .s    (sum[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  // The final carry is the sum MSB; 7+7+1 fits in four bits.
  assign sum[3] = carry[3];

  hex_to_7seg u_dec (
    .hex (sum),
    .seg (seg_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_reg <= SEG_BLANK;
    end else begin
      seg_reg <= seg_next;
    end
  end

  assign {CA, CB, CC, CD, CE, CF, CG} = seg_reg;

endmodule

// File: tb/tb_topworld.sv
// Directed bench for topworld: expected digit patterns are queued when
// switches are driven and popped when the registered display is sampled.
module tb_topworld;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic Cin = 1'b0;
  logic a0 = 1'b0, a1 = 1'b0, a2 = 1'b0;
  logic b0 = 1'b0, b1 = 1'b0, b2 = 1'b0;
  logic CA, CB, CC, CD, CE, CF, CG;
  logic [6:0] seg;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } exp_t;

  exp_t sb[$];

  // Independent reference of the lab's display encoding, {a..g} active-low.
  logic [6:0] ref_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  localparam logic [6:0] BLANK = 7'b1111111;

  topworld #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Cin   (Cin),
    .a0    (a0),
    .a1    (a1),
    .a2    (a2),
    .b0    (b0),
    .b1    (b1),
    .b2    (b2),
    .CA    (CA),
    .CB    (CB),
    .CC    (CC),
    .CD    (CD),
    .CE    (CE),
    .CF    (CF),
    .CG    (CG)
  );

  always #5 clk = ~clk;

  assign seg = {CA, CB, CC, CD, CE, CF, CG};

  task automatic set_sw(input int a, input int b, input int c);
    logic [2:0] av;
    logic [2:0] bv;
    av = a[2:0];
    bv = b[2:0];
    {a2, a1, a0} = av;
    {b2, b1, b0} = bv;
    Cin = c[0];
  endtask

  task automatic drive(input int a, input int b, input int c);
    @(negedge clk);
    set_sw(a, b, c);
  endtask

  task automatic push(input string tag, input logic [6:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%b required=queued entry", seg);
    end else begin
      e = sb.pop_front();
      assert (seg === e.exp) else begin
        errors++;
        $error("FAIL %s: observed=%b required=%b", e.tag, seg, e.exp);
      end
    end
  endtask

  task automatic edge_check();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic wait_edges(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
  endtask

  initial begin
    logic [15:0] hit;
    int s;

    // Reset held with random switches: display must stay blank.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1));
      push("reset_blank", BLANK);
      edge_check();
    end

    // Release with switches at 0: first edge shows "0".
    @(negedge clk);
    set_sw(0, 0, 0);
    rst_n = 1'b1;
    push("release_zero", ref_tab[0]);
    edge_check();
    wait_edges(3);

    // 3+4+1: old digit for two edges, "8" exactly on the third.
    drive(3, 4, 1);
    push("lat_edge1", ref_tab[0]);
    edge_check();
    push("lat_edge2", ref_tab[0]);
    edge_check();
    push("lat_edge3", ref_tab[8]);
    edge_check();

    drive(7, 7, 1);
    wait_edges(4);
    push("max_F", ref_tab[15]);
    edge_check();
    drive(0, 0, 1);
    wait_edges(4);
    push("cin_only_1", ref_tab[1]);
    edge_check();

    // Exhaustive sweep, each held five cycles.
    hit = '0;
    for (int v = 0; v < 128; v++) begin
      drive(v % 8, (v / 8) % 8, v / 64);
      s = (v % 8) + ((v / 8) % 8) + (v / 64);
      wait_edges(4);
      push($sformatf("sweep_a%0d_b%0d_c%0d", v % 8, (v / 8) % 8, v / 64), ref_tab[s]);
      edge_check();
      for (int d = 0; d < 16; d++) begin
        if (seg === ref_tab[d]) hit[d] = 1'b1;
      end
    end
    checks++;
    assert (hit === 16'hFFFF) else begin
      errors++;
      $error("FAIL digit_coverage: observed=%h required=ffff", hit);
    end

    // Asynchronous reset pulse while showing "d".
    drive(6, 7, 0);
    wait_edges(4);
    push("show_d", ref_tab[13]);
    edge_check();
    #2;
    rst_n = 1'b0;
    #1;
    push("async_blank", BLANK);
    compare();
    @(negedge clk);
    rst_n = 1'b1;
    push("post_rst_edge1", ref_tab[0]);
    edge_check();
    @(posedge clk);
    push("post_rst_edge3", ref_tab[13]);
    edge_check();

    // All switches change together from 0 to 7+7+1.
    drive(0, 0, 0);
    wait_edges(4);
    push("simul_start_0", ref_tab[0]);
    edge_check();
    drive(7, 7, 1);
    wait_edges(3);
    push("simul_edge4", ref_tab[15]);
    edge_check();
    for (int i = 0; i < 3; i++) begin
      push("simul_hold", ref_tab[15]);
      edge_check();
    end

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: observed=%0d required=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
